// File: rtl/btn_led_mode_ctrl.sv
// Two-button / three-LED board sequencer: synchronise and debounce the buttons,
// then let a mode FSM drive the LEDs with live logic, a press counter or a chase.
module btn_led_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 12000000,
    parameter int CHASE_CYCLES    = 3000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_a,
    input  logic       i_btn_b,
    output logic       o_led_1,
    output logic       o_led_2,
    output logic       o_led_3,
    output logic [1:0] o_mode
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CHASE_W = (CHASE_CYCLES > 1) ? $clog2(CHASE_CYCLES) : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CHASE_W-1:0] CHASE_LAST = CHASE_W'(CHASE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOGIC    = 2'd0,
        ST_COUNT    = 2'd1,
        ST_CHASE    = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    // Mode selected by a long two-button hold from the given mode.
    function automatic state_t mode_after(input state_t cur);
        state_t nxt;
        case (cur)
            ST_LOGIC: nxt = ST_COUNT;
            ST_COUNT: nxt = ST_CHASE;
            ST_CHASE: nxt = ST_LOGIC;
            default:  nxt = ST_LOGIC;
        endcase
        return nxt;
    endfunction

    // Index 0 is button A, index 1 is button B.
    logic [1:0]            meta_r;
    logic [1:0]            sync_r;
    logic [1:0]            deb_r;
    logic [1:0]            deb_d_r;
    logic [1:0][DB_W-1:0]  db_cnt_r;

    state_t               state_r, state_nxt_s;
    state_t               next_mode_r, next_mode_nxt_s;
    logic [HOLD_W-1:0]    hold_r, hold_nxt_s;
    logic [2:0]           cnt_r, cnt_nxt_s;
    logic [2:0]           pos_r, pos_nxt_s;
    logic                 dir_rev_r, dir_rev_nxt_s;
    logic                 pause_r, pause_nxt_s;
    logic [CHASE_W-1:0]   timer_r, timer_nxt_s;
    logic [2:0]           lit_s;

    logic rise_a_s, rise_b_s, step_a_s, step_b_s;

    assign rise_a_s = deb_r[0] & ~deb_d_r[0];
    assign rise_b_s = deb_r[1] & ~deb_d_r[1];
    // An edge only counts when the other button is fully released.
    assign step_a_s = rise_a_s & ~rise_b_s & ~deb_r[1];
    assign step_b_s = rise_b_s & ~rise_a_s & ~deb_r[0];

    // Two-flop synchroniser and per-button debounce filter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_r   <= 2'b00;
            sync_r   <= 2'b00;
            deb_r    <= 2'b00;
            deb_d_r  <= 2'b00;
            db_cnt_r <= {2{{DB_W{1'b0}}}};
        end else begin
            meta_r  <= {i_btn_b, i_btn_a};
            sync_r  <= meta_r;
            deb_d_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    deb_r[i]    <= sync_r[i];
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Mode FSM state and per-mode datapath registers, plus registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= ST_LOGIC;
            next_mode_r <= ST_LOGIC;
            hold_r      <= {HOLD_W{1'b0}};
            cnt_r       <= 3'd0;
            pos_r       <= 3'b001;
            dir_rev_r   <= 1'b0;
            pause_r     <= 1'b0;
            timer_r     <= {CHASE_W{1'b0}};
            o_led_1     <= 1'b1;
            o_led_2     <= 1'b1;
            o_led_3     <= 1'b1;
            o_mode      <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            next_mode_r <= next_mode_nxt_s;
            hold_r      <= hold_nxt_s;
            cnt_r       <= cnt_nxt_s;
            pos_r       <= pos_nxt_s;
            dir_rev_r   <= dir_rev_nxt_s;
            pause_r     <= pause_nxt_s;
            timer_r     <= timer_nxt_s;
            o_led_1     <= ~lit_s[0];
            o_led_2     <= ~lit_s[1];
            o_led_3     <= ~lit_s[2];
            o_mode      <= state_r;
        end
    end

    // Next-state, per-mode updates and LED pattern (1 = lit)
    always_comb begin
        state_nxt_s     = state_r;
        next_mode_nxt_s = next_mode_r;
        hold_nxt_s      = hold_r;
        cnt_nxt_s       = cnt_r;
        pos_nxt_s       = pos_r;
        dir_rev_nxt_s   = dir_rev_r;
        pause_nxt_s     = pause_r;
        timer_nxt_s     = timer_r;
        lit_s           = 3'b000;

        case (state_r)
            ST_LOGIC: begin
                lit_s = {deb_r[0] ^ deb_r[1], deb_r[0] | deb_r[1], deb_r[0] & deb_r[1]};
            end
            ST_COUNT: begin
                lit_s = cnt_r;
                if (step_a_s) begin
                    cnt_nxt_s = cnt_r + 3'd1;
                end else if (step_b_s) begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_CHASE: begin
                lit_s = pos_r;
                if (!pause_r) begin
                    if (timer_r == CHASE_LAST) begin
                        timer_nxt_s = {CHASE_W{1'b0}};
                        pos_nxt_s   = dir_rev_r ? {pos_r[0], pos_r[2:1]} : {pos_r[1:0], pos_r[2]};
                    end else begin
                        timer_nxt_s = timer_r + CHASE_W'(1);
                    end
                end else begin
                    timer_nxt_s = timer_r;
                end
                if (step_a_s) begin
                    pause_nxt_s = ~pause_r;
                end else begin
                    pause_nxt_s = pause_r;
                end
                if (step_b_s) begin
                    dir_rev_nxt_s = ~dir_rev_r;
                end else begin
                    dir_rev_nxt_s = dir_rev_r;
                end
            end
            ST_WAIT_REL: begin
                lit_s = 3'b111;
                if (!deb_r[0] && !deb_r[1]) begin
                    // Entry initialisation for whichever mode comes next.
                    state_nxt_s   = next_mode_r;
                    cnt_nxt_s     = 3'd0;
                    pos_nxt_s     = 3'b001;
                    dir_rev_nxt_s = 1'b0;
                    pause_nxt_s   = 1'b0;
                    timer_nxt_s   = {CHASE_W{1'b0}};
                end else begin
                    state_nxt_s = ST_WAIT_REL;
                end
            end
            default: begin
                state_nxt_s = ST_LOGIC;
            end
        endcase

        if (state_r == ST_WAIT_REL) begin
            hold_nxt_s = {HOLD_W{1'b0}};
        end else if (deb_r[0] && deb_r[1]) begin
            if (hold_r == HOLD_LAST) begin
                hold_nxt_s      = {HOLD_W{1'b0}};
                next_mode_nxt_s = mode_after(state_r);
                state_nxt_s     = ST_WAIT_REL;
            end else begin
                hold_nxt_s = hold_r + HOLD_W'(1);
            end
        end else begin
            hold_nxt_s = {HOLD_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_btn_led_mode_ctrl.sv
// Directed bench for btn_led_mode_ctrl with short debounce/hold/chase periods;
// every check compares {o_mode, o_led_3, o_led_2, o_led_1} to a hand-derived value.
module tb_btn_led_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_a;
    logic       btn_b;
    logic       led_1;
    logic       led_2;
    logic       led_3;
    logic [1:0] mode;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    btn_led_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .CHASE_CYCLES   (3)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_btn_a(btn_a),
        .i_btn_b(btn_b),
        .o_led_1(led_1),
        .o_led_2(led_2),
        .o_led_3(led_3),
        .o_mode (mode)
    );

    task automatic check(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        observed = {mode, led_3, led_2, led_1};
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b0;
        cycles(3);
        check("reset_state", 5'b00111);
        rst = 1'b0;
        cycles(10);
        check("logic_idle", 5'b00111);

        // Debounce and LOGIC mode
        btn_a = 1'b1; cycles(3); btn_a = 1'b0; cycles(10);
        check("glitch_rejected", 5'b00111);
        btn_a = 1'b1; cycles(6);
        check("a_before_debounce", 5'b00111);
        cycles(1);
        check("a_logic_or_xor", 5'b00001);
        cycles(3);
        btn_b = 1'b1; cycles(7);
        check("ab_logic_and", 5'b00100);

        // Hold both -> WAIT_REL, partial release, full release -> COUNT
        cycles(10);
        check("hold_to_wait_rel", 5'b11000);
        btn_a = 1'b0; cycles(12);
        check("one_released_stays", 5'b11000);
        btn_b = 1'b0; cycles(10);
        check("enter_count", 5'b01111);

        // COUNT wrap and chord rejection
        btn_b = 1'b1; cycles(10); btn_b = 1'b0; cycles(10);
        check("count_wrap_down", 5'b01000);
        btn_a = 1'b1; cycles(10); btn_a = 1'b0; cycles(10);
        check("count_wrap_up", 5'b01111);
        for (int i = 0; i < 3; i++) begin
            btn_a = 1'b1; cycles(10); btn_a = 1'b0; cycles(10);
        end
        check("count_three", 5'b01100);
        btn_a = 1'b1; cycles(10);
        check("count_four_a_held", 5'b01011);
        btn_b = 1'b1; cycles(5); btn_b = 1'b0; cycles(10);
        btn_a = 1'b0; cycles(10);
        check("count_chord_ignored", 5'b01011);

        // COUNT -> CHASE
        btn_a = 1'b1; btn_b = 1'b1; cycles(25);
        check("count_to_wait", 5'b11000);
        btn_a = 1'b0; btn_b = 1'b0; cycles(8);
        check("chase_led1", 5'b10110);
        cycles(3); check("chase_led2", 5'b10101);
        cycles(3); check("chase_led3", 5'b10011);
        cycles(3); check("chase_wrap_led1", 5'b10110);

        // Direction toggle takes effect at the next step
        btn_b = 1'b1; cycles(5); btn_b = 1'b0; cycles(4);
        check("chase_rev_led2", 5'b10101);
        cycles(3); check("chase_rev_led1", 5'b10110);
        cycles(3); check("chase_rev_led3", 5'b10011);

        // Pause freezes the chase, second press resumes from the frozen LED
        btn_a = 1'b1; cycles(5); btn_a = 1'b0; cycles(8);
        check("chase_paused_early", 5'b10110);
        cycles(12);
        check("chase_paused_late", 5'b10110);
        btn_a = 1'b1; cycles(5); btn_a = 1'b0; cycles(3);
        check("chase_resume_hold", 5'b10110);
        cycles(1); check("chase_resume_step", 5'b10011);
        cycles(3); check("chase_running", 5'b10101);

        // CHASE -> LOGIC closes the mode loop
        btn_a = 1'b1; btn_b = 1'b1; cycles(25);
        check("chase_to_wait", 5'b11000);
        btn_a = 1'b0; btn_b = 1'b0; cycles(10);
        check("back_to_logic", 5'b00111);
        btn_b = 1'b1; cycles(10);
        check("logic_b_only", 5'b00001);
        btn_a = 1'b1; cycles(7);
        check("logic_both", 5'b00100);

        // Asynchronous reset in the middle of a hold
        cycles(2);
        #2 rst = 1'b1;
        #1 check("async_reset", 5'b00111);
        cycles(2);
        rst = 1'b0;
        cycles(6);
        check("post_reset_dark", 5'b00111);
        cycles(1);
        check("post_reset_logic", 5'b00100);
        btn_a = 1'b0; btn_b = 1'b0; cycles(10);

        if (failed > 0) $display("%0d comparisons did not hold", failed);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/btn_led_mode_ctrl.md
Name: btn_led_mode_ctrl

Overview:
- Sequencer that owns the board's two push-buttons and three LEDs.
- Synchronises and debounces both raw buttons, then detects press edges.
- Runs a mode FSM that decides what drives the LEDs: live AND/OR/XOR logic, an up/down press counter, or a timed LED chase.
- Top-level board block; replaces direct button-to-LED wiring.

Parameters:
- DEBOUNCE_CYCLES, 120000: consecutive stable cycles required before a debounced button changes (10 ms at 12 MHz).
- HOLD_CYCLES, 12000000: cycles both buttons must be held together to advance mode (1 s).
- CHASE_CYCLES, 3000000: cycles per chase step (250 ms).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_btn_a  in  1  raw button A; 1 = pressed; asynchronous to i_clk.
- i_btn_b  in  1  raw button B; 1 = pressed; asynchronous to i_clk.
- o_led_1  out  1  LED 1, active-low (0 = lit).
- o_led_2  out  1  LED 2, active-low.
- o_led_3  out  1  LED 3, active-low.
- o_mode  out  2  current mode: 0 LOGIC, 1 COUNT, 2 CHASE, 3 WAIT_REL.

Behaviour:
- Reset (async assert, sync release): all sync/debounce/counter registers 0; state LOGIC; o_mode=0; o_led_1..3=1 (all dark). Reset mid-hold, mid-count or mid-chase discards everything.
- Input path: 2-FF synchroniser per button.
  - Per-button debounce counter ($clog2(DEBOUNCE_CYCLES) bits): clears when synced value equals debounced value.
  - Otherwise increments; at DEBOUNCE_CYCLES-1 the debounced value flips and the counter clears.
  - Raw change to debounced change: 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Edge detect: rise_a / rise_b are one-cycle pulses on a debounced 0->1 transition.
- All outputs are registered: 1 cycle from debounced/state change to LED change.
- LOGIC: led1 = a&b, led2 = a|b, led3 = a^b (debounced values; LED lit = 1).
- COUNT: 3-bit counter cnt; led1 = cnt[0], led2 = cnt[1], led3 = cnt[2].
  - rise_a alone increments, wrapping 7->0.
  - rise_b alone decrements, wrapping 0->7.
  - Ignored: rise_a and rise_b in the same cycle; an edge on one button while the other is debounced-high (chord in progress).
- CHASE: one-hot position pos, starting 001 (LED1). Step timer counts 0..CHASE_CYCLES-1.
  - At terminal count pos rotates: forward 001->010->100->001; reverse opposite.
  - rise_a toggles pause. While paused the timer holds and pos is frozen.
  - rise_b toggles direction; takes effect at the next step and does not reset the timer.
  - Same chord-ignore rule as COUNT.
- Mode advance (LOGIC, COUNT, CHASE):
  - Hold counter increments while both debounced buttons are 1; clears when either is 0.
  - At HOLD_CYCLES-1: store next mode (LOGIC->COUNT->CHASE->LOGIC) and go to WAIT_REL.
- WAIT_REL: all LEDs lit (outputs 0) as acknowledge; edges ignored.
  - Leaves only when both debounced buttons are 0, entering the stored mode next cycle.
  - Entry actions: COUNT clears cnt to 0; CHASE sets pos=001, forward, unpaused, timer 0.
  - LOGIC needs no init. COUNT/CHASE state is not retained across mode changes.
- o_mode is registered together with the LEDs.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, CHASE_CYCLES=3):
- Reset: assert i_rst mid-run with buttons pressed -> o_led_1..3=1 and o_mode=0 immediately (async); after release, LEDs track LOGIC.
- Debounce + LOGIC: A pulses high for 3 cycles -> no LED change. A held 10 cycles -> o_led_2=0, o_led_3=0, o_led_1=1 exactly 2+4+1 cycles after the edge. Add B -> o_led_1=0, o_led_3=1.
- Mode advance: hold A+B for 8 debounced cycles -> o_mode=3, all LEDs 0. Release both -> o_mode=1, LEDs all 1 (cnt=0). Releasing one button only -> stays in o_mode=3.
- COUNT wrap: from cnt=0 press B once -> cnt=7, LEDs 000. Then press A -> cnt=0, LEDs 111. Press A three times -> cnt=3 (o_led_1=0, o_led_2=0, o_led_3=1). B press while A held -> no change.
- CHASE: enter CHASE -> pos LED1, advancing every 3 cycles 1->2->3->1.
  - Press B -> reverse (3->2->1) from the next step.
  - Press A -> frozen for 20 cycles; press A again -> resumes from the frozen LED.
- Full cycle: three hold/release sequences -> o_mode 0->1->2->0; LOGIC outputs valid again.
